alu_rs: RTL and testbench

//  ALU reservation station and issue scheduler. Holds dispatched ALU ops until both operands are ready.

---
 rtl/cpu_pkg.sv | 63 ++++++
 rtl/rs_find_first.sv | 22 ++
 rtl/alu_rs.sv | 133 +++++++++++++
 tb/tb_alu_rs.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types for the ALU reservation station: opcode encodings, entry layout
// and the operand wake-up helper used by both dispatch and snooping.
package cpu_pkg;

    localparam int OPCODE_ALU_WIDTH = 4;
    localparam int ROB_TAG_WIDTH    = 4;
    localparam int DATA_WIDTH       = 32;

    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_AND  = 4'd1;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_OR   = 4'd2;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_XOR  = 4'd3;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_ADD  = 4'd4;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_SUB  = 4'd5;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_SLL  = 4'd6;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_SRL  = 4'd7;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_SRA  = 4'd8;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_SLT  = 4'd9;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_SLTU = 4'd10;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_BEQ  = 4'd11;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_BNE  = 4'd12;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_BLT  = 4'd13;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_BGE  = 4'd14;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_JALR = 4'd15;

    typedef struct packed {
        logic                     rdy;
        logic [DATA_WIDTH-1:0]    val;
        logic [ROB_TAG_WIDTH-1:0] tag;
    } rs_operand_t;

    typedef struct packed {
        logic                        busy;
        logic [OPCODE_ALU_WIDTH-1:0] opcode;
        rs_operand_t                 lhs;
        rs_operand_t                 rhs;
        logic [ROB_TAG_WIDTH-1:0]    dest;
    } rs_entry_t;

    // ALU bus is checked first so it wins if both buses carry the same tag.
    function automatic rs_operand_t wake_operand(
        input rs_operand_t              op,
        input logic                     alu_done,
        input logic [DATA_WIDTH-1:0]    alu_value,
        input logic [ROB_TAG_WIDTH-1:0] alu_tag,
        input logic                     lsb_done,
        input logic [DATA_WIDTH-1:0]    lsb_value,
        input logic [ROB_TAG_WIDTH-1:0] lsb_tag
    );
        rs_operand_t res;
        res = op;
        if (!op.rdy) begin
            if (alu_done && (alu_tag == op.tag)) begin
                res.rdy = 1'b1;
                res.val = alu_value;
            end else if (lsb_done && (lsb_tag == op.tag)) begin
                res.rdy = 1'b1;
                res.val = lsb_value;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_find_first.sv
// Find-first-set over a request vector: lowest set index plus a found flag.
module rs_find_first #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (req[i] && !found) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops, snoops ALU/LSB result buses for
// operand wake-up, and issues the lowest-index fully ready entry once per cycle.
module alu_rs
    import cpu_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_TAG_WIDTH,
    parameter int RS_WIDTH  = 3
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        clear_signal,
    input  logic                        inst_valid,
    input  logic [OPCODE_ALU_WIDTH-1:0] inst_opcode,
    input  logic                        inst_lhs_rdy,
    input  logic [31:0]                 inst_lhs_val,
    input  logic [ROB_WIDTH-1:0]        inst_lhs_tag,
    input  logic                        inst_rhs_rdy,
    input  logic [31:0]                 inst_rhs_val,
    input  logic [ROB_WIDTH-1:0]        inst_rhs_tag,
    input  logic [ROB_WIDTH-1:0]        inst_tag,
    output logic                        rs_full,
    input  logic                        alu_done,
    input  logic [31:0]                 alu_value,
    input  logic [ROB_WIDTH-1:0]        alu_tag,
    input  logic                        lsb_done,
    input  logic [31:0]                 lsb_value,
    input  logic [ROB_WIDTH-1:0]        lsb_tag,
    output logic                        cal_signal,
    output logic [OPCODE_ALU_WIDTH-1:0] opcode,
    output logic [31:0]                 lhs,
    output logic [31:0]                 rhs,
    output logic [ROB_WIDTH-1:0]        tag
);

    localparam int unsigned RS_SIZE = 1 << RS_WIDTH;

    rs_entry_t             entries [RS_SIZE];
    rs_entry_t             new_entry;
    logic [RS_SIZE-1:0]    busy_vec;
    logic [RS_SIZE-1:0]    ready_vec;
    logic [RS_WIDTH-1:0]   free_idx;
    logic [RS_WIDTH-1:0]   ready_idx;
    logic                  free_found;
    logic                  ready_found;

    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = entries[i].busy;
            ready_vec[i] = entries[i].busy && entries[i].lhs.rdy && entries[i].rhs.rdy;
        end
    end

    assign rs_full = &busy_vec;

    rs_find_first #(.WIDTH(RS_SIZE), .IDX_W(RS_WIDTH)) u_free_find (
        .req   (~busy_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_find_first #(.WIDTH(RS_SIZE), .IDX_W(RS_WIDTH)) u_ready_find (
        .req   (ready_vec),
        .idx   (ready_idx),
        .found (ready_found)
    );

    // Incoming operands see the same-cycle broadcast before being stored.
    always_comb begin
        new_entry         = '0;
        new_entry.busy    = 1'b1;
        new_entry.opcode  = inst_opcode;
        new_entry.dest    = inst_tag;
        new_entry.lhs.rdy = inst_lhs_rdy;
        new_entry.lhs.val = inst_lhs_val;
        new_entry.lhs.tag = inst_lhs_tag;
        new_entry.rhs.rdy = inst_rhs_rdy;
        new_entry.rhs.val = inst_rhs_val;
        new_entry.rhs.tag = inst_rhs_tag;
        new_entry.lhs = wake_operand(new_entry.lhs, alu_done, alu_value, alu_tag,
                                     lsb_done, lsb_value, lsb_tag);
        new_entry.rhs = wake_operand(new_entry.rhs, alu_done, alu_value, alu_tag,
                                     lsb_done, lsb_value, lsb_tag);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                entries[i] <= '0;
            end
            cal_signal <= 1'b0;
            opcode     <= '0;
            lhs        <= '0;
            rhs        <= '0;
            tag        <= '0;
        end else if (rdy_in) begin
            if (clear_signal) begin
                for (int unsigned i = 0; i < RS_SIZE; i++) begin
                    entries[i].busy <= 1'b0;
                end
                cal_signal <= 1'b0;
            end else begin
                for (int unsigned i = 0; i < RS_SIZE; i++) begin
                    if (entries[i].busy) begin
                        entries[i].lhs <= wake_operand(entries[i].lhs, alu_done, alu_value,
                                                       alu_tag, lsb_done, lsb_value, lsb_tag);
                        entries[i].rhs <= wake_operand(entries[i].rhs, alu_done, alu_value,
                                                       alu_tag, lsb_done, lsb_value, lsb_tag);
                    end
                end

                // Selection uses registered readiness; a just-woken operand waits a cycle.
                if (ready_found) begin
                    cal_signal              <= 1'b1;
                    opcode                  <= entries[ready_idx].opcode;
                    lhs                     <= entries[ready_idx].lhs.val;
                    rhs                     <= entries[ready_idx].rhs.val;
                    tag                     <= entries[ready_idx].dest;
                    entries[ready_idx].busy <= 1'b0;
                end else begin
                    cal_signal <= 1'b0;
                end

                if (inst_valid && free_found) begin
                    entries[free_idx] <= new_entry;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs: dispatch, wake-up, select order, clear and pause.
module tb_alu_rs;
    import cpu_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_signal;
    logic        inst_valid;
    logic [3:0]  inst_opcode;
    logic        inst_lhs_rdy;
    logic [31:0] inst_lhs_val;
    logic [3:0]  inst_lhs_tag;
    logic        inst_rhs_rdy;
    logic [31:0] inst_rhs_val;
    logic [3:0]  inst_rhs_tag;
    logic [3:0]  inst_tag;
    logic        rs_full;
    logic        alu_done;
    logic [31:0] alu_value;
    logic [3:0]  alu_tag;
    logic        lsb_done;
    logic [31:0] lsb_value;
    logic [3:0]  lsb_tag;
    logic        cal_signal;
    logic [3:0]  opcode;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [3:0]  tag;

    int assertions = 0;
    int failures   = 0;

    alu_rs #(.ROB_WIDTH(4), .RS_WIDTH(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_signal(clear_signal),
        .inst_valid(inst_valid), .inst_opcode(inst_opcode),
        .inst_lhs_rdy(inst_lhs_rdy), .inst_lhs_val(inst_lhs_val), .inst_lhs_tag(inst_lhs_tag),
        .inst_rhs_rdy(inst_rhs_rdy), .inst_rhs_val(inst_rhs_val), .inst_rhs_tag(inst_rhs_tag),
        .inst_tag(inst_tag), .rs_full(rs_full),
        .alu_done(alu_done), .alu_value(alu_value), .alu_tag(alu_tag),
        .lsb_done(lsb_done), .lsb_value(lsb_value), .lsb_tag(lsb_tag),
        .cal_signal(cal_signal), .opcode(opcode), .lhs(lhs), .rhs(rhs), .tag(tag)
    );

    always #5 clk_in = ~clk_in;

    // Dispatching into a full station is a protocol error on the bench side.
    always @(posedge clk_in) begin
        if (!rst_in && rdy_in && inst_valid) begin
            assertions++;
            if (rs_full) begin
                $display("FAIL dispatch_while_full: rs_full=%b inst_valid=%b required no dispatch", rs_full, inst_valid);
                failures++;
            end
        end
    end

    task automatic step();
        @(negedge clk_in);
    endtask

    task automatic idle_inputs();
        inst_valid = 1'b0; inst_opcode = '0;
        inst_lhs_rdy = 1'b0; inst_lhs_val = '0; inst_lhs_tag = '0;
        inst_rhs_rdy = 1'b0; inst_rhs_val = '0; inst_rhs_tag = '0;
        inst_tag = '0; clear_signal = 1'b0;
        alu_done = 1'b0; alu_value = '0; alu_tag = '0;
        lsb_done = 1'b0; lsb_value = '0; lsb_tag = '0;
    endtask

    task automatic drive_inst(input logic [3:0] op, input logic lr, input logic [31:0] lv,
                              input logic [3:0] lt, input logic rr, input logic [31:0] rv,
                              input logic [3:0] rt, input logic [3:0] dt);
        inst_valid = 1'b1; inst_opcode = op;
        inst_lhs_rdy = lr; inst_lhs_val = lv; inst_lhs_tag = lt;
        inst_rhs_rdy = rr; inst_rhs_val = rv; inst_rhs_tag = rt;
        inst_tag = dt;
    endtask

    task automatic test_reset();
        logic [72:0] exp;
        exp = '0;
        assertions++;
        if ({cal_signal, opcode, lhs, rhs, tag} !== exp || rs_full !== 1'b0) begin
            $display("FAIL reset_state: got %h full=%b required %h full=0",
                     {cal_signal, opcode, lhs, rhs, tag}, rs_full, exp);
            failures++;
        end
        drive_inst(ALU_AND, 1, 32'h11, 0, 1, 32'h22, 0, 4'd1);
        step();
        drive_inst(ALU_OR, 1, 32'h33, 0, 1, 32'h44, 0, 4'd2);
        step();
        idle_inputs();
        assertions++;
        if ({cal_signal, tag} !== {1'b1, 4'd1}) begin
            $display("FAIL reset_pre_issue: got cal=%b tag=%0d required cal=1 tag=1", cal_signal, tag);
            failures++;
        end
        #2 rst_in = 1'b1;
        #1;
        assertions++;
        if ({cal_signal, opcode, tag, rs_full} !== 10'b0) begin
            $display("FAIL reset_async: got cal=%b op=%0d tag=%0d full=%b required all 0",
                     cal_signal, opcode, tag, rs_full);
            failures++;
        end
        #1 rst_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            assertions++;
            if (cal_signal !== 1'b0) begin
                $display("FAIL reset_no_stale_issue: cycle %0d got cal=%b required 0", i, cal_signal);
                failures++;
            end
        end
    endtask

    task automatic test_basic_issue();
        drive_inst(ALU_ADD, 1, 32'd5, 0, 1, 32'd7, 0, 4'd3);
        step();
        idle_inputs();
        assertions++;
        if (cal_signal !== 1'b0) begin
            $display("FAIL basic_latency: got cal=%b required 0 one edge after dispatch", cal_signal);
            failures++;
        end
        step();
        assertions++;
        if ({cal_signal, opcode, lhs, rhs, tag} !== {1'b1, 4'd4, 32'd5, 32'd7, 4'd3}) begin
            $display("FAIL basic_issue: got %b %0d %h %h %0d required 1 4 5 7 3",
                     cal_signal, opcode, lhs, rhs, tag);
            failures++;
        end
        step();
        assertions++;
        if ({cal_signal, opcode, lhs, rhs, tag} !== {1'b0, 4'd4, 32'd5, 32'd7, 4'd3}) begin
            $display("FAIL basic_pulse_end: got %b %0d %h %h %0d required 0 4 5 7 3",
                     cal_signal, opcode, lhs, rhs, tag);
            failures++;
        end
    endtask

    task automatic test_wakeup();
        drive_inst(ALU_SUB, 1, 32'd20, 0, 0, 32'd0, 4'd6, 4'd1);
        step();
        idle_inputs();
        step();
        alu_done = 1'b1; alu_value = 32'h10; alu_tag = 4'd6;
        assertions++;
        if (cal_signal !== 1'b0) begin
            $display("FAIL wakeup_wait: got cal=%b required 0 while rhs pending", cal_signal);
            failures++;
        end
        step();
        idle_inputs();
        assertions++;
        if (cal_signal !== 1'b0) begin
            $display("FAIL wakeup_latency: got cal=%b required 0 on wake edge", cal_signal);
            failures++;
        end
        step();
        assertions++;
        if ({cal_signal, opcode, lhs, rhs, tag} !== {1'b1, 4'd5, 32'd20, 32'h10, 4'd1}) begin
            $display("FAIL wakeup_issue: got %b %0d %h %h %0d required 1 5 14 10 1",
                     cal_signal, opcode, lhs, rhs, tag);
            failures++;
        end
        step();
    endtask

    task automatic test_dispatch_bypass();
        drive_inst(ALU_XOR, 0, 32'd0, 4'd2, 1, 32'd3, 0, 4'd4);
        lsb_done = 1'b1; lsb_value = 32'hAB; lsb_tag = 4'd2;
        step();
        idle_inputs();
        step();
        assertions++;
        if ({cal_signal, opcode, lhs, rhs, tag} !== {1'b1, 4'd3, 32'hAB, 32'd3, 4'd4}) begin
            $display("FAIL bypass_issue: got %b %0d %h %h %0d required 1 3 ab 3 4",
                     cal_signal, opcode, lhs, rhs, tag);
            failures++;
        end
        step();
    endtask

    task automatic test_full_priority();
        for (int i = 0; i < 8; i++) begin
            drive_inst(ALU_ADD, 0, 32'd0, (i == 2 || i == 5) ? 4'd9 : 4'd11,
                       1, 32'h100 + i, 0, 4'(i));
            step();
            if (i == 6) begin
                assertions++;
                if (rs_full !== 1'b0) begin
                    $display("FAIL full_seven: got rs_full=%b required 0 with 7 busy", rs_full);
                    failures++;
                end
            end
        end
        idle_inputs();
        assertions++;
        if ({rs_full, cal_signal} !== 2'b10) begin
            $display("FAIL full_eight: got full=%b cal=%b required full=1 cal=0", rs_full, cal_signal);
            failures++;
        end
        alu_done = 1'b1; alu_value = 32'h55; alu_tag = 4'd9;
        step();
        idle_inputs();
        step();
        assertions++;
        if ({cal_signal, lhs, rhs, tag, rs_full} !== {1'b1, 32'h55, 32'h102, 4'd2, 1'b0}) begin
            $display("FAIL priority_first: got cal=%b lhs=%h rhs=%h tag=%0d full=%b required 1 55 102 2 0",
                     cal_signal, lhs, rhs, tag, rs_full);
            failures++;
        end
        step();
        assertions++;
        if ({cal_signal, lhs, rhs, tag} !== {1'b1, 32'h55, 32'h105, 4'd5}) begin
            $display("FAIL priority_second: got cal=%b lhs=%h rhs=%h tag=%0d required 1 55 105 5",
                     cal_signal, lhs, rhs, tag);
            failures++;
        end
        step();
        assertions++;
        if (cal_signal !== 1'b0) begin
            $display("FAIL priority_drain: got cal=%b required 0", cal_signal);
            failures++;
        end
        clear_signal = 1'b1;
        step();
        clear_signal = 1'b0;
        assertions++;
        if (rs_full !== 1'b0) begin
            $display("FAIL full_clear: got rs_full=%b required 0", rs_full);
            failures++;
        end
    endtask

    task automatic load_four();
        for (int i = 0; i < 3; i++) begin
            drive_inst(ALU_ADD, 0, 32'd0, 4'd12, 1, 32'(i), 0, 4'(8 + i));
            step();
        end
        drive_inst(ALU_SLT, 1, 32'd1, 0, 1, 32'd2, 0, 4'd13);
        step();
        idle_inputs();
    endtask

    task automatic test_clear_and_pause();
        load_four();
        clear_signal = 1'b1;
        step();
        clear_signal = 1'b0;
        alu_done = 1'b1; alu_value = 32'h77; alu_tag = 4'd12;
        assertions++;
        if ({cal_signal, rs_full} !== 2'b00) begin
            $display("FAIL clear_effect: got cal=%b full=%b required 0 0", cal_signal, rs_full);
            failures++;
        end
        step();
        alu_done = 1'b0;
        step();
        assertions++;
        if (cal_signal !== 1'b0) begin
            $display("FAIL clear_no_stale: got cal=%b required 0", cal_signal);
            failures++;
        end

        load_four();
        rdy_in = 1'b0; clear_signal = 1'b1;
        step();
        rdy_in = 1'b1; clear_signal = 1'b0;
        assertions++;
        if (cal_signal !== 1'b0) begin
            $display("FAIL paused_clear_hold: got cal=%b required 0", cal_signal);
            failures++;
        end
        step();
        assertions++;
        if ({cal_signal, opcode, lhs, rhs, tag} !== {1'b1, 4'd9, 32'd1, 32'd2, 4'd13}) begin
            $display("FAIL paused_clear_ignored: got %b %0d %h %h %0d required 1 9 1 2 d",
                     cal_signal, opcode, lhs, rhs, tag);
            failures++;
        end
        rdy_in = 1'b0;
        step();
        assertions++;
        if ({cal_signal, opcode, lhs, rhs, tag} !== {1'b1, 4'd9, 32'd1, 32'd2, 4'd13}) begin
            $display("FAIL pause_hold: got %b %0d %h %h %0d required 1 9 1 2 d",
                     cal_signal, opcode, lhs, rhs, tag);
            failures++;
        end
        rdy_in = 1'b1;
        alu_done = 1'b1; alu_value = 32'h77; alu_tag = 4'd12;
        step();
        idle_inputs();
        assertions++;
        if (cal_signal !== 1'b0) begin
            $display("FAIL back_to_back_gap: got cal=%b required 0", cal_signal);
            failures++;
        end
        for (int i = 0; i < 3; i++) begin
            step();
            assertions++;
            if ({cal_signal, opcode, lhs, rhs, tag} !== {1'b1, 4'd4, 32'h77, 32'(i), 4'(8 + i)}) begin
                $display("FAIL back_to_back_%0d: got %b %0d %h %h %0d required 1 4 77 %h %0d",
                         i, cal_signal, opcode, lhs, rhs, tag, i, 8 + i);
                failures++;
            end
        end
        step();
        assertions++;
        if ({cal_signal, rs_full} !== 2'b00) begin
            $display("FAIL back_to_back_drain: got cal=%b full=%b required 0 0", cal_signal, rs_full);
            failures++;
        end
    endtask

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        idle_inputs();
        step();
        step();
        rst_in = 1'b0;
        test_reset();
        test_basic_issue();
        test_wakeup();
        test_dispatch_bypass();
        test_full_priority();
        test_clear_and_pause();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
